// File: rtl/sram_port_arbiter_if.sv
// Requester and SRAM-side signal bundle for sram_port_arbiter.
// slave is the arbiter view; master is the requester/SRAM view.
interface sram_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_RD     = 4
);
  logic [NUM_RD-1:0]            rd_req_i;
  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr_i;
  logic [NUM_RD-1:0]            rd_gnt_o;
  logic [NUM_RD-1:0]            rsp_valid_o;
  logic [NUM_RD*DATA_WIDTH-1:0] rsp_data_o;
  logic [1:0]                   wr_req_i;
  logic [2*ADDR_WIDTH-1:0]      wr_addr_i;
  logic [2*DATA_WIDTH-1:0]      wr_data_i;
  logic [1:0]                   wr_gnt_o;
  logic                         sram_we_o;
  logic [ADDR_WIDTH-1:0]        sram_waddr_o;
  logic [DATA_WIDTH-1:0]        sram_wdata_o;
  logic [ADDR_WIDTH-1:0]        sram_addr_ra_o;
  logic [ADDR_WIDTH-1:0]        sram_addr_rb_o;
  logic [DATA_WIDTH-1:0]        sram_rdata_ra_i;
  logic [DATA_WIDTH-1:0]        sram_rdata_rb_i;

  modport slave (
    input  rd_req_i, rd_addr_i,
    input  wr_req_i, wr_addr_i, wr_data_i,
    input  sram_rdata_ra_i, sram_rdata_rb_i,
    output rd_gnt_o, rsp_valid_o, rsp_data_o,
    output wr_gnt_o, sram_we_o,
    output sram_waddr_o, sram_wdata_o,
    output sram_addr_ra_o, sram_addr_rb_o
  );

  modport master (
    output rd_req_i, rd_addr_i,
    output wr_req_i, wr_addr_i, wr_data_i,
    output sram_rdata_ra_i, sram_rdata_rb_i,
    input  rd_gnt_o, rsp_valid_o, rsp_data_o,
    input  wr_gnt_o, sram_we_o,
    input  sram_waddr_o, sram_wdata_o,
    input  sram_addr_ra_o, sram_addr_rb_o
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one 2R1W SRAM between NUM_RD readers
// and two writers, with same-cycle write-to-read forwarding.
module sram_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_RD     = 4
) (
  input logic                clk_i,
  input logic                rst_i,
  sram_port_arbiter_if.slave bus
);
  localparam int PW = $clog2(NUM_RD);
  localparam logic [PW:0] NRD = (PW+1)'(NUM_RD);
  typedef logic [PW-1:0] idx_t;

  idx_t                  rd_ptr_q;
  logic                  wr_ptr_q;
  logic                  valid_a_q;
  logic                  valid_b_q;
  idx_t                  own_a_q;
  idx_t                  own_b_q;
  logic                  byp_a_q;
  logic                  byp_b_q;
  logic [DATA_WIDTH-1:0] byp_data_q;

  logic [NUM_RD-1:0]     rd_gnt;
  logic                  found_a;
  logic                  found_b;
  idx_t                  own_a;
  idx_t                  own_b;
  idx_t                  rd_ptr_d;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [ADDR_WIDTH-1:0] addr_b;

  logic [1:0]            wr_gnt;
  logic                  wsel;
  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  byp_a;
  logic                  byp_b;

  logic [NUM_RD-1:0]            rsp_valid;
  logic [NUM_RD*DATA_WIDTH-1:0] rsp_data;

  // Rotating scan from rd_ptr_q; first hit takes port A, second port B.
  always_comb begin
    logic [PW:0] idx;
    rd_gnt  = '0;
    found_a = 1'b0;
    found_b = 1'b0;
    own_a   = '0;
    own_b   = '0;
    idx     = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      idx = {1'b0, rd_ptr_q} + (PW+1)'(i);
      if (idx >= NRD) idx = idx - NRD;
      if (bus.rd_req_i[idx[PW-1:0]] && !found_b) begin
        rd_gnt[idx[PW-1:0]] = 1'b1;
        if (!found_a) begin
          found_a = 1'b1;
          own_a   = idx[PW-1:0];
        end else begin
          found_b = 1'b1;
          own_b   = idx[PW-1:0];
        end
      end
    end
  end

  always_comb begin
    logic [PW:0] nxt;
    nxt = {1'b0, (found_b ? own_b : own_a)} + 1'b1;
    if (nxt >= NRD) nxt = '0;
    rd_ptr_d = nxt[PW-1:0];
  end

  always_comb begin
    addr_a = '0;
    addr_b = '0;
    if (found_a)
      addr_a = bus.rd_addr_i[int'(own_a)*ADDR_WIDTH +: ADDR_WIDTH];
    if (found_b)
      addr_b = bus.rd_addr_i[int'(own_b)*ADDR_WIDTH +: ADDR_WIDTH];
  end

  always_comb begin
    wr_gnt = '0;
    wsel   = bus.wr_req_i[wr_ptr_q] ? wr_ptr_q : ~wr_ptr_q;
    if (bus.wr_req_i[wsel]) wr_gnt[wsel] = 1'b1;
  end

  assign we = |wr_gnt;

  always_comb begin
    waddr = '0;
    wdata = '0;
    if (we) begin
      waddr = bus.wr_addr_i[int'(wsel)*ADDR_WIDTH +: ADDR_WIDTH];
      wdata = bus.wr_data_i[int'(wsel)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // The SRAM returns old data on a read/write collision; forward instead.
  assign byp_a = found_a && we && (addr_a == waddr);
  assign byp_b = found_b && we && (addr_b == waddr);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= 1'b0;
      valid_a_q  <= 1'b0;
      valid_b_q  <= 1'b0;
      own_a_q    <= '0;
      own_b_q    <= '0;
      byp_a_q    <= 1'b0;
      byp_b_q    <= 1'b0;
      byp_data_q <= '0;
    end else begin
      if (found_a) rd_ptr_q <= rd_ptr_d;
      if (we) wr_ptr_q <= ~wsel;
      valid_a_q  <= found_a;
      valid_b_q  <= found_b;
      own_a_q    <= own_a;
      own_b_q    <= own_b;
      byp_a_q    <= byp_a;
      byp_b_q    <= byp_b;
      byp_data_q <= wdata;
    end
  end

  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (valid_a_q && own_a_q == idx_t'(k)) begin
        rsp_valid[k] = 1'b1;
        rsp_data[k*DATA_WIDTH +: DATA_WIDTH] =
          byp_a_q ? byp_data_q : bus.sram_rdata_ra_i;
      end
      if (valid_b_q && own_b_q == idx_t'(k)) begin
        rsp_valid[k] = 1'b1;
        rsp_data[k*DATA_WIDTH +: DATA_WIDTH] =
          byp_b_q ? byp_data_q : bus.sram_rdata_rb_i;
      end
    end
  end

  assign bus.rd_gnt_o       = rd_gnt;
  assign bus.rsp_valid_o    = rsp_valid;
  assign bus.rsp_data_o     = rsp_data;
  assign bus.wr_gnt_o       = wr_gnt;
  assign bus.sram_we_o      = we;
  assign bus.sram_waddr_o   = waddr;
  assign bus.sram_wdata_o   = wdata;
  assign bus.sram_addr_ra_o = addr_a;
  assign bus.sram_addr_rb_o = addr_b;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with an SRAM model and a
// cycle-level reference model checked every negedge.
module tb_sram_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NR = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sram_port_arbiter_if #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)
  ) bus ();

  sram_port_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  // SRAM: synchronous read, old data on same-address collision
  logic [DW-1:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    bus.sram_rdata_ra_i = '0;
    bus.sram_rdata_rb_i = '0;
  end
  always @(posedge clk) begin
    bus.sram_rdata_ra_i <= mem[bus.sram_addr_ra_o];
    bus.sram_rdata_rb_i <= mem[bus.sram_addr_rb_o];
    if (bus.sram_we_o) mem[bus.sram_waddr_o] <= bus.sram_wdata_o;
  end

  task automatic chk(input string nm,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference model: logical memory contents and expected responses
  logic [DW-1:0] mmem [256];
  int            mptr = 0;
  int            mwp = 0;
  logic [NR-1:0] mvalid = '0;
  logic [DW-1:0] mdata [NR];
  int            nptr = 0;
  int            nwp = 0;
  logic [NR-1:0] nvalid = '0;
  logic [DW-1:0] ndata [NR];
  logic          nwe = 1'b0;
  logic [AW-1:0] nwa = '0;
  logic [DW-1:0] nwd = '0;

  initial begin
    for (int i = 0; i < 256; i++) mmem[i] = '0;
    for (int i = 0; i < NR; i++) begin
      mdata[i] = '0;
      ndata[i] = '0;
    end
  end

  always @(negedge clk) begin
    int p, wp, na, last, w;
    logic [NR-1:0]    eg;
    logic [1:0]       ewg;
    logic [AW-1:0]    ea, eb, ka;
    logic [NR-1:0]    erv;
    logic [NR*DW-1:0] erd;
    p  = rst ? 0 : mptr;
    wp = rst ? 0 : mwp;
    eg = '0; ea = '0; eb = '0; na = 0; last = p;
    nvalid = '0;
    for (int i = 0; i < NR; i++) ndata[i] = '0;
    w = -1;
    if (bus.wr_req_i == 2'b11) w = wp;
    else if (bus.wr_req_i[0]) w = 0;
    else if (bus.wr_req_i[1]) w = 1;
    ewg = '0;
    nwe = (w >= 0);
    nwa = '0;
    nwd = '0;
    if (nwe) begin
      ewg[w] = 1'b1;
      nwa = bus.wr_addr_i[w*AW +: AW];
      nwd = bus.wr_data_i[w*DW +: DW];
    end
    for (int i = 0; i < NR; i++) begin
      int k;
      k = (p + i) % NR;
      if (bus.rd_req_i[k] && na < 2) begin
        ka = bus.rd_addr_i[k*AW +: AW];
        if (na == 0) ea = ka;
        else eb = ka;
        eg[k] = 1'b1;
        na++;
        last = k;
        nvalid[k] = 1'b1;
        ndata[k] = (nwe && nwa == ka) ? nwd : mmem[ka];
      end
    end
    nptr = (na > 0) ? (last + 1) % NR : p;
    nwp  = nwe ? 1 - w : wp;
    erd = '0;
    for (int k = 0; k < NR; k++) begin
      erv[k] = !rst && mvalid[k];
      if (erv[k]) erd[k*DW +: DW] = mdata[k];
    end
    chk("rd_gnt", bus.rd_gnt_o, eg);
    chk("wr_gnt", bus.wr_gnt_o, ewg);
    chk("sram_we", bus.sram_we_o, nwe);
    chk("waddr", bus.sram_waddr_o, nwa);
    chk("wdata", bus.sram_wdata_o, nwd);
    chk("addr_ra", bus.sram_addr_ra_o, ea);
    chk("addr_rb", bus.sram_addr_rb_o, eb);
    chk("rsp_valid", bus.rsp_valid_o, erv);
    chk("rsp_data", bus.rsp_data_o, erd);
  end

  always @(posedge clk) begin
    if (nwe) mmem[nwa] <= nwd;
    if (rst) begin
      mptr   <= 0;
      mwp    <= 0;
      mvalid <= '0;
    end else begin
      mptr   <= nptr;
      mwp    <= nwp;
      mvalid <= nvalid;
      for (int k = 0; k < NR; k++) mdata[k] <= ndata[k];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic set_ra(input int k, input logic [AW-1:0] a);
    bus.rd_addr_i[k*AW +: AW] = a;
  endtask

  task automatic set_w(input int k, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    bus.wr_addr_i[k*AW +: AW] = a;
    bus.wr_data_i[k*DW +: DW] = d;
  endtask

  function automatic logic [DW-1:0] slice(input int k);
    return bus.rsp_data_o[k*DW +: DW];
  endfunction

  initial begin
    rst = 1'b1;
    bus.rd_req_i  = '0;
    bus.rd_addr_i = '0;
    bus.wr_req_i  = '0;
    bus.wr_addr_i = '0;
    bus.wr_data_i = '0;
    tick();
    tick();
    at_neg();
    chk("rst_valid", bus.rsp_valid_o, '0);
    chk("rst_data", bus.rsp_data_o, '0);
    tick();
    rst = 1'b0;

    // write-then-read
    bus.wr_req_i = 2'b01;
    set_w(0, 8'h10, 32'hDEADBEEF);
    at_neg();
    chk("t1_wgnt", bus.wr_gnt_o, 2'b01);
    chk("t1_we", bus.sram_we_o, 1'b1);
    tick();
    bus.wr_req_i = '0;
    bus.rd_req_i = 4'b0100;
    set_ra(2, 8'h10);
    at_neg();
    chk("t1_rgnt", bus.rd_gnt_o, 4'b0100);
    chk("t1_ra", bus.sram_addr_ra_o, 8'h10);
    tick();
    bus.rd_req_i = '0;
    at_neg();
    chk("t1_rv", bus.rsp_valid_o, 4'b0100);
    chk("t1_rd", slice(2), 32'hDEADBEEF);

    // requester 3 alone moves the pointer back to 0
    tick();
    bus.rd_req_i = 4'b1000;
    set_ra(3, 8'h10);
    tick();
    bus.rd_req_i = 4'b1111;
    for (int k = 0; k < NR; k++) set_ra(k, AW'(8'h10 + k));
    at_neg();
    chk("t2_g1", bus.rd_gnt_o, 4'b0011);
    tick();
    at_neg();
    chk("t2_g2", bus.rd_gnt_o, 4'b1100);
    chk("t2_rv1", bus.rsp_valid_o, 4'b0011);
    chk("t2_rd0", slice(0), 32'hDEADBEEF);
    tick();
    at_neg();
    chk("t2_g3", bus.rd_gnt_o, 4'b0011);
    chk("t2_rv2", bus.rsp_valid_o, 4'b1100);
    tick();
    bus.rd_req_i = '0;
    at_neg();
    chk("t2_rv3", bus.rsp_valid_o, 4'b0011);

    // read/write collision on 0x22
    tick();
    bus.wr_req_i = 2'b10;
    set_w(1, 8'h22, 32'h12345678);
    bus.rd_req_i = 4'b1001;
    set_ra(0, 8'h22);
    set_ra(3, 8'h22);
    at_neg();
    chk("t3_rgnt", bus.rd_gnt_o, 4'b1001);
    chk("t3_wgnt", bus.wr_gnt_o, 2'b10);
    tick();
    bus.wr_req_i = '0;
    bus.rd_req_i = 4'b0001;
    at_neg();
    chk("t3_rv", bus.rsp_valid_o, 4'b1001);
    chk("t3_byp0", slice(0), 32'h12345678);
    chk("t3_byp3", slice(3), 32'h12345678);
    tick();
    bus.rd_req_i = '0;
    at_neg();
    chk("t3_rv2", bus.rsp_valid_o, 4'b0001);
    chk("t3_sram", slice(0), 32'h12345678);

    // write fairness
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.wr_req_i = 2'b11;
      set_w(0, 8'h30, 32'hAAAA0000 + i);
      set_w(1, 8'h31, 32'hBBBB0000 + i);
      at_neg();
      chk("t4_wgnt", bus.wr_gnt_o, (i % 2 == 0) ? 2'b01 : 2'b10);
      chk("t4_we", bus.sram_we_o, 1'b1);
    end
    tick();
    bus.wr_req_i = '0;
    bus.rd_req_i = 4'b0011;
    set_ra(0, 8'h30);
    set_ra(1, 8'h31);
    at_neg();
    chk("t4_rgnt", bus.rd_gnt_o, 4'b0011);
    tick();
    bus.rd_req_i = '0;
    at_neg();
    chk("t4_d30", slice(0), 32'hAAAA0002);
    chk("t4_d31", slice(1), 32'hBBBB0003);

    // single reader
    tick();
    bus.rd_req_i = 4'b0010;
    set_ra(1, 8'h31);
    at_neg();
    chk("t5_gnt1", bus.rd_gnt_o, 4'b0010);
    chk("t5_ra", bus.sram_addr_ra_o, 8'h31);
    chk("t5_rb", bus.sram_addr_rb_o, 8'h00);
    tick();
    bus.rd_req_i = 4'b0001;
    set_ra(0, 8'h30);
    at_neg();
    chk("t5_gnt0", bus.rd_gnt_o, 4'b0001);

    // reset with reads in flight
    tick();
    bus.rd_req_i = 4'b0011;
    set_ra(0, 8'h10);
    set_ra(1, 8'h31);
    at_neg();
    chk("t6_gnt", bus.rd_gnt_o, 4'b0011);
    tick();
    rst = 1'b1;
    bus.rd_req_i = '0;
    at_neg();
    chk("t6_rv_a", bus.rsp_valid_o, '0);
    tick();
    at_neg();
    chk("t6_rv_b", bus.rsp_valid_o, '0);
    tick();
    rst = 1'b0;
    bus.rd_req_i = 4'b0011;
    at_neg();
    chk("t6_gnt2", bus.rd_gnt_o, 4'b0011);
    chk("t6_ra", bus.sram_addr_ra_o, 8'h10);
    chk("t6_rb", bus.sram_addr_rb_o, 8'h31);
    tick();
    bus.rd_req_i = '0;
    at_neg();
    chk("t6_rv", bus.rsp_valid_o, 4'b0011);
    chk("t6_d0", slice(0), 32'hDEADBEEF);
    chk("t6_d1", slice(1), 32'hBBBB0003);
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one 2R1W SRAM (synchronous read, 1-cycle latency) between NUM_RD read requesters and two write requesters.
- Grants up to two reads per cycle onto read ports A/B and one write per cycle, all round-robin.
- Routes registered read data back to the owning requester.
- Forwards write data when a granted read hits the same address as the same-cycle write.

Parameters:
- DATA_WIDTH, 32, SRAM word width.
- ADDR_WIDTH, 8, SRAM address width.
- NUM_RD, 4, number of read requesters (2..8).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- rd_req_i  in  NUM_RD  per-requester read request.
- rd_addr_i  in  NUM_RD*ADDR_WIDTH  read addresses; requester k uses slice k.
- rd_gnt_o  out  NUM_RD  read grant, combinational, same cycle as request.
- rsp_valid_o  out  NUM_RD  read response valid, one cycle after grant.
- rsp_data_o  out  NUM_RD*DATA_WIDTH  read response data; slice k belongs to requester k.
- wr_req_i  in  2  write requests.
- wr_addr_i  in  2*ADDR_WIDTH  write addresses.
- wr_data_i  in  2*DATA_WIDTH  write data.
- wr_gnt_o  out  2  write grant, combinational.
- sram_we_o  out  1  SRAM write enable.
- sram_waddr_o  out  ADDR_WIDTH  SRAM write address.
- sram_wdata_o  out  DATA_WIDTH  SRAM write data.
- sram_addr_ra_o  out  ADDR_WIDTH  SRAM read address A.
- sram_addr_rb_o  out  ADDR_WIDTH  SRAM read address B.
- sram_rdata_ra_i  in  DATA_WIDTH  SRAM read data A, valid the cycle after its address is presented.
- sram_rdata_rb_i  in  DATA_WIDTH  SRAM read data B, valid the cycle after its address is presented.

Behaviour:
- Handshake: a requester holds req and addr/data stable until it sees gnt. A transfer completes in the cycle where req & gnt are both high. No back-pressure on responses.
- Read arbitration:
  - rd_ptr_q (clog2(NUM_RD) bits) sets the search start.
  - Scan indices rd_ptr_q, rd_ptr_q+1, ... modulo NUM_RD.
  - First requester found → port A; second → port B. At most 2 grants per cycle.
  - No requester found for a port → its address drives 0.
- Read pointer update: if ≥1 grant, rd_ptr_q ← (index of last granted requester + 1) mod NUM_RD; if no grant, it holds.
- Write arbitration:
  - wr_ptr_q (1 bit) picks the preferred writer.
  - Both requesting → preferred writer granted, then wr_ptr_q ← other writer.
  - Exactly one requesting → that writer granted, then wr_ptr_q ← the other writer.
  - sram_we_o = |wr_gnt_o. When idle, waddr and wdata drive 0.
- Response pipeline:
  - Register valid_a_q/valid_b_q, owner index own_a_q/own_b_q, and bypass flags byp_a_q/byp_b_q with registered bypass data.
  - Next cycle, rsp_valid_o[own] = 1.
  - rsp_data_o slice = bypass data if the bypass flag is set, else sram_rdata_ra_i/rb_i.
  - Ungranted slices: valid 0, data 0.
- Same-cycle RAW: granted read address == granted write address with sram_we_o=1 → response returns the new wdata. The SRAM returns old data on a collision; the bypass hides this.
- A requester may be re-granted in the cycle its previous response returns, giving throughput of 1 read per requester per cycle.
- Reset (async assert, sync deassert):
  - rd_ptr_q=0, wr_ptr_q=0, all valid/bypass flags 0.
  - rsp_valid_o=0, rsp_data_o=0.
  - Reads in flight at reset are dropped; no response is ever produced for them.
- Grants are combinational from req and pointers. During reset they still follow the req inputs using pointer value 0, but responses are suppressed until reset deasserts.

Test Plan:
- Write-then-read: writer0 writes addr 0x10 = 0xDEADBEEF; next cycle requester 2 reads 0x10 → gnt same cycle, rsp_valid_o[2]=1 one cycle later with 0xDEADBEEF.
- Four readers request continuously, rd_ptr_q=0 → cycle 1 grants {0,1}, cycle 2 {2,3}, cycle 3 {0,1}. Each gets exactly one response per grant with correct data.
- Collision: writer1 writes 0x22=0x12345678 while requesters 0 and 3 read 0x22 in the same cycle → both responses 0x12345678. Repeat reading 0x22 without a write → returns 0x12345678 from the SRAM.
- Write fairness: both writers request for 4 cycles → grants alternate 0,1,0,1. sram_we_o=1 every cycle; contents at both addresses match the last granted data.
- Single reader: only requester 1 requests → granted on port A, port B address 0, rd_ptr_q becomes 2. Requester 0 requesting next cycle is still granted.
- Reset mid-operation: assert rst_i the cycle after grants to requesters 0 and 1 → rsp_valid_o stays 0. After deassert, requester 0 is granted first (ptr=0).
